bpu_table_ctrl: RTL and testbench

//   Owns the single write port of the branch predictor tables (BHT counters + BTB tag/target/valid).

---
 rtl/bpu_table_ctrl_pkg.sv | 33 +++
 rtl/bpu_upd_fifo.sv | 46 ++++
 rtl/bpu_table_ctrl.sv | 131 +++++++++++++
 tb/tb_bpu_table_ctrl.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/bpu_table_ctrl_pkg.sv
// Shared types and constants for the branch-predictor table write-port controller.
// The BHT and BTB use the same index/tag slices defined here.
package bpu_table_ctrl_pkg;

   localparam int IDX_W  = 6;
   localparam int TAG_W  = 8;
   localparam int QDEPTH = 2;

   typedef enum logic [1:0] {
      ST_INIT  = 2'd0,
      ST_IDLE  = 2'd1,
      ST_FLUSH = 2'd2
   } state_e;

   // Only the slices the tables consume are queued, not the whole PC.
   typedef struct packed {
      logic [IDX_W-1:0] idx;
      logic [TAG_W-1:0] tag;
      logic             taken;
      logic [31:0]      target;
   } upd_entry_t;

   localparam int ENTRY_W = $bits(upd_entry_t);

   function automatic logic [IDX_W-1:0] pc_idx(input logic [31:0] pc);
      return pc[IDX_W+1:2];
   endfunction

   function automatic logic [TAG_W-1:0] pc_tag(input logic [31:0] pc);
      return pc[IDX_W+TAG_W+1:IDX_W+2];
   endfunction

endpackage

// File: rtl/bpu_upd_fifo.sv
// Small synchronous FIFO holding resolved-branch updates; sync clear drops all entries.
module bpu_upd_fifo #(
   parameter int DEPTH = 2,
   parameter int W     = 8
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         clr_i,
   input  logic         push_i,
   input  logic [W-1:0] din_i,
   input  logic         pop_i,
   output logic [W-1:0] dout_o,
   output logic         full_o,
   output logic         empty_o
);
   localparam int AW = $clog2(DEPTH);

   logic [AW:0]  wr_ptr_q, rd_ptr_q;
   logic [W-1:0] mem_q [DEPTH];
   logic         do_push, do_pop;

   // Extra pointer bit distinguishes full from empty when the low bits match.
   assign empty_o = (wr_ptr_q == rd_ptr_q);
   assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign do_push = push_i && !full_o && !clr_i;
   assign do_pop  = pop_i && !empty_o && !clr_i;
   assign dout_o  = mem_q[rd_ptr_q[AW-1:0]];

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else if (clr_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
         if (do_pop)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din_i;
   end

endmodule

// File: rtl/bpu_table_ctrl.sv
// Single write port of the BHT/BTB: clears every entry after reset or flush,
// otherwise drains queued branch-resolution updates one per cycle.
//
// state | meaning
// INIT  | post-reset walk, one clear write per cycle
// IDLE  | tables valid, pop and write queued updates
// FLUSH | requested walk, identical to INIT
module bpu_table_ctrl
   import bpu_table_ctrl_pkg::*;
(
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             flush_req_i,
   input  logic             upd_valid_i,
   output logic             upd_ready_o,
   input  logic [31:0]      upd_pc_i,
   input  logic             upd_taken_i,
   input  logic [31:0]      upd_target_i,
   output logic             wr_en_o,
   output logic             wr_clear_o,
   output logic [IDX_W-1:0] wr_idx_o,
   output logic [TAG_W-1:0] wr_tag_o,
   output logic             wr_taken_o,
   output logic [31:0]      wr_target_o,
   output logic             busy_o
);
   state_e           state_q, state_d;
   logic [IDX_W-1:0] walk_cnt_q, walk_cnt_d;
   logic             wr_en_q, wr_en_d, wr_clear_q, wr_clear_d;
   logic [IDX_W-1:0] wr_idx_q, wr_idx_d;
   logic [TAG_W-1:0] wr_tag_q, wr_tag_d;
   logic             wr_taken_q, wr_taken_d;
   logic [31:0]      wr_target_q, wr_target_d;

   logic             fifo_full, fifo_empty, fifo_pop, fifo_push;
   upd_entry_t       push_ent, head_ent;
   logic [ENTRY_W-1:0] head_raw;

   // rst_i gates ready so nothing is acknowledged while the block is held in reset.
   assign upd_ready_o = !rst_i && !fifo_full && !flush_req_i;
   assign fifo_push   = upd_valid_i && upd_ready_o;

   assign push_ent.idx    = pc_idx(upd_pc_i);
   assign push_ent.tag    = pc_tag(upd_pc_i);
   assign push_ent.taken  = upd_taken_i;
   assign push_ent.target = upd_target_i;
   assign head_ent        = upd_entry_t'(head_raw);

   bpu_upd_fifo #(
      .DEPTH (QDEPTH),
      .W     (ENTRY_W)
   ) u_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .clr_i   (flush_req_i),
      .push_i  (fifo_push),
      .din_i   (push_ent),
      .pop_i   (fifo_pop),
      .dout_o  (head_raw),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   always_comb begin
      state_d     = state_q;
      walk_cnt_d  = walk_cnt_q;
      wr_en_d     = 1'b0;
      wr_clear_d  = 1'b0;
      wr_idx_d    = '0;
      wr_tag_d    = '0;
      wr_taken_d  = 1'b0;
      wr_target_d = '0;
      fifo_pop    = 1'b0;
      if (flush_req_i) begin
         state_d    = ST_FLUSH;
         walk_cnt_d = '0;
      end else begin
         case (state_q)
            ST_INIT, ST_FLUSH: begin
               wr_en_d    = 1'b1;
               wr_clear_d = 1'b1;
               wr_idx_d   = walk_cnt_q;
               walk_cnt_d = walk_cnt_q + IDX_W'(1);
               if (walk_cnt_q == '1) state_d = ST_IDLE;
            end
            ST_IDLE: begin
               if (!fifo_empty) begin
                  fifo_pop    = 1'b1;
                  wr_en_d     = 1'b1;
                  wr_idx_d    = head_ent.idx;
                  wr_tag_d    = head_ent.tag;
                  wr_taken_d  = head_ent.taken;
                  wr_target_d = head_ent.target;
               end
            end
            default: state_d = ST_INIT;
         endcase
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q     <= ST_INIT;
         walk_cnt_q  <= '0;
         wr_en_q     <= 1'b0;
         wr_clear_q  <= 1'b0;
         wr_idx_q    <= '0;
         wr_tag_q    <= '0;
         wr_taken_q  <= 1'b0;
         wr_target_q <= '0;
      end else begin
         state_q     <= state_d;
         walk_cnt_q  <= walk_cnt_d;
         wr_en_q     <= wr_en_d;
         wr_clear_q  <= wr_clear_d;
         wr_idx_q    <= wr_idx_d;
         wr_tag_q    <= wr_tag_d;
         wr_taken_q  <= wr_taken_d;
         wr_target_q <= wr_target_d;
      end
   end

   assign wr_en_o     = wr_en_q;
   assign wr_clear_o  = wr_clear_q;
   assign wr_idx_o    = wr_idx_q;
   assign wr_tag_o    = wr_tag_q;
   assign wr_taken_o  = wr_taken_q;
   assign wr_target_o = wr_target_q;
   assign busy_o      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_bpu_table_ctrl.sv
// Bench for bpu_table_ctrl: directed scenarios plus random traffic against a
// queue-based reference model of the table write port.
module tb_bpu_table_ctrl;
   localparam int IDX_W  = 6;
   localparam int TAG_W  = 8;
   localparam int QDEPTH = 2;
   localparam int NENT   = 1 << IDX_W;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             flush = 1'b0, valid = 1'b0, taken = 1'b0;
   logic [31:0]      pc = '0, target = '0;
   logic             upd_ready, wr_en, wr_clear, wr_taken, busy;
   logic [IDX_W-1:0] wr_idx;
   logic [TAG_W-1:0] wr_tag;
   logic [31:0]      wr_target;

   bpu_table_ctrl dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .flush_req_i  (flush),
      .upd_valid_i  (valid),
      .upd_ready_o  (upd_ready),
      .upd_pc_i     (pc),
      .upd_taken_i  (taken),
      .upd_target_i (target),
      .wr_en_o      (wr_en),
      .wr_clear_o   (wr_clear),
      .wr_idx_o     (wr_idx),
      .wr_tag_o     (wr_tag),
      .wr_taken_o   (wr_taken),
      .wr_target_o  (wr_target),
      .busy_o       (busy)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: pending updates as a queue, the walk as "next index to clear".
   typedef struct {
      int          idx;
      int          tag;
      bit          taken;
      logic [31:0] target;
   } ent_t;

   ent_t        mq[$];
   bit          m_walk = 1'b1;
   int          m_next = 0;
   bit          m_acc  = 1'b0;
   bit          e_en = 1'b0, e_clr = 1'b0, e_taken = 1'b0;
   int          e_idx = 0, e_tag = 0;
   logic [31:0] e_tgt = '0;

   function automatic void model_reset();
      mq.delete();
      m_walk = 1'b1;
      m_next = 0;
      m_acc  = 1'b0;
      e_en = 1'b0; e_clr = 1'b0; e_taken = 1'b0;
      e_idx = 0; e_tag = 0; e_tgt = '0;
   endfunction

   function automatic void model_edge();
      ent_t ne;
      bit   acc;
      acc = valid && !flush && (mq.size() < QDEPTH);
      m_acc = 1'b0;
      e_en = 1'b0; e_clr = 1'b0; e_taken = 1'b0;
      e_idx = 0; e_tag = 0; e_tgt = '0;
      if (rst) begin
         model_reset();
         return;
      end
      if (flush) begin
         mq.delete();
         m_walk = 1'b1;
         m_next = 0;
         return;
      end
      if (m_walk) begin
         e_en = 1'b1; e_clr = 1'b1; e_idx = m_next;
         m_next++;
         if (m_next == NENT) m_walk = 1'b0;
      end else if (mq.size() > 0) begin
         ne = mq.pop_front();
         e_en = 1'b1; e_idx = ne.idx; e_tag = ne.tag; e_taken = ne.taken; e_tgt = ne.target;
      end
      if (acc) begin
         ne.idx    = int'((pc / 4) % NENT);
         ne.tag    = int'((pc / (4 * NENT)) % (1 << TAG_W));
         ne.taken  = taken;
         ne.target = target;
         mq.push_back(ne);
         m_acc = 1'b1;
      end
   endfunction

   task automatic check_outputs();
      check("wr_en", wr_en, e_en);
      check("busy", busy, m_walk);
      if (e_en) begin
         check("wr_clear", wr_clear, e_clr);
         check("wr_idx", wr_idx, e_idx);
         check("wr_tag", wr_tag, e_tag);
         check("wr_taken", wr_taken, e_taken);
         check("wr_target", wr_target, e_tgt);
      end
   endtask

   // Called at a negedge: drive, check ready, advance one edge, check the port.
   task automatic cycle(input bit f, input bit v);
      flush = f;
      valid = v;
      #1;
      check("upd_ready", upd_ready, !rst && !f && (mq.size() < QDEPTH));
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check_outputs();
   endtask

   task automatic set_upd(input logic [31:0] p, input bit t, input logic [31:0] tg);
      pc = p; taken = t; target = tg;
   endtask

   int n_clear;

   initial begin
      model_reset();
      // 1: reset, then a full clearing walk
      for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0);
      check("rst_wr_en", wr_en, 0);
      check("rst_busy", busy, 1);
      rst = 1'b0;
      n_clear = 0;
      for (int i = 0; i < NENT + 2; i++) begin
         cycle(1'b0, 1'b0);
         if (wr_en && wr_clear) n_clear++;
      end
      check("t1_walk_len", n_clear, NENT);

      // 2: single update on an idle, empty queue
      set_upd(32'h0000_0104, 1'b1, 32'h0000_0200);
      cycle(1'b0, 1'b1);
      cycle(1'b0, 1'b0);
      check("t2_idx", wr_idx, 1);
      check("t2_tag", wr_tag, 1);
      check("t2_target", wr_target, 32'h200);
      cycle(1'b0, 1'b0);

      // 3: updates offered during a walk queue up, the third waits
      cycle(1'b1, 1'b0);
      for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0);
      set_upd(32'h0000_1238, 1'b1, 32'h0000_4000);
      cycle(1'b0, 1'b1);
      set_upd(32'h0001_567c, 1'b0, 32'h0000_8000);
      cycle(1'b0, 1'b1);
      set_upd(32'h00ab_cdf0, 1'b1, 32'h1234_5678);
      for (int i = 0; i < NENT + 10; i++) begin
         cycle(1'b0, 1'b1);
         if (m_acc) break;
      end
      check("t3_c_accepted", m_acc, 1);
      for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0);

      // 4: flush discards a queued update
      set_upd(32'h0000_0ff0, 1'b1, 32'hdead_beec);
      cycle(1'b0, 1'b1);
      cycle(1'b1, 1'b0);
      check("t4_no_stale", wr_en, 0);
      n_clear = 0;
      for (int i = 0; i < NENT + 3; i++) begin
         cycle(1'b0, 1'b0);
         if (wr_en && wr_clear) n_clear++;
         check("t4_no_update", wr_en && !wr_clear, 0);
      end
      check("t4_walk_len", n_clear, NENT);

      // 5: flush mid-walk restarts at index 0
      cycle(1'b1, 1'b0);
      for (int i = 0; i < 31; i++) cycle(1'b0, 1'b0);
      check("t5_at_30", wr_idx, 30);
      cycle(1'b1, 1'b0);
      cycle(1'b0, 1'b0);
      check("t5_restart", wr_idx, 0);
      for (int i = 0; i < NENT + 2; i++) cycle(1'b0, 1'b0);

      // 6: async reset while an update write is on the port
      set_upd(32'h0000_0048, 1'b1, 32'h0000_0100);
      cycle(1'b0, 1'b1);
      cycle(1'b0, 1'b0);
      check("t6_upd_on_port", wr_en && !wr_clear, 1);
      rst = 1'b1;
      #1;
      model_reset();
      check("t6_async_wr_en", wr_en, 0);
      check("t6_async_busy", busy, 1);
      @(negedge clk);
      cycle(1'b0, 1'b0);
      rst = 1'b0;
      cycle(1'b0, 1'b0);
      check("t6_restart", wr_idx, 0);
      for (int i = 0; i < NENT + 2; i++) cycle(1'b0, 1'b0);

      // random traffic
      for (int i = 0; i < 3000; i++) begin
         set_upd($urandom, 1'($urandom_range(0, 1)), $urandom);
         cycle($urandom_range(0, 59) == 0, $urandom_range(0, 1) == 1);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
